// File: rtl/cfg_switch_matrix.sv
// Run-time configurable routing switch box joining four inout pin banks through a serial shadow/active image.
// Optional build macro CFG_SWITCH_READBACK_EN adds cfg_dout, the registered shadow-chain tail.
module cfg_switch_matrix #(
  parameter int NT   = 5,
  parameter int NS   = 4,
  parameter int IDXW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cfg_start,
  input  logic          cfg_valid,
  input  logic          cfg_din,
  input  logic          cfg_commit,
  output logic          cfg_busy,
  output logic          cfg_ready,
  output logic          cfg_done,
  output logic          cfg_err,
`ifdef CFG_SWITCH_READBACK_EN
  output logic          cfg_dout,
`endif
  inout  wire  [NT-1:0] wtop,
  inout  wire  [NT-1:0] wbottom,
  inout  wire  [NS-1:0] wleft,
  inout  wire  [NS-1:0] wright
);

  localparam int EW    = 3 + IDXW;
  localparam int NE    = 2 * NT + 2 * NS;
  localparam int TOTAL = NE * EW;
  localparam int CW    = $clog2(TOTAL + 1);
  localparam int PW    = 1 << IDXW;

  typedef enum logic [1:0] {IDLE, SHIFT, FULL} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             done_q;
  logic             shift_en, commit_en;
  logic [TOTAL-1:0] shadow_q;
  logic [TOTAL-1:0] active_q;

  // A restart outranks every other request in the same cycle.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    shift_en  = 1'b0;
    commit_en = 1'b0;
    if (cfg_start) begin
      state_d = SHIFT;
      cnt_d   = '0;
      err_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_valid || cfg_commit) err_d = 1'b1;
        end
        SHIFT: begin
          if (cfg_commit) err_d = 1'b1;
          if (cfg_valid) begin
            shift_en = 1'b1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(TOTAL - 1)) state_d = FULL;
          end
        end
        FULL: begin
          if (cfg_valid) err_d = 1'b1;
          if (cfg_commit) begin
            commit_en = 1'b1;
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      done_q  <= commit_en;
      if (shift_en)  shadow_q <= {shadow_q[TOTAL-2:0], cfg_din};
      if (commit_en) active_q <= shadow_q;
    end
  end

  assign cfg_busy  = (state_q == SHIFT);
  assign cfg_ready = (state_q == FULL);
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

`ifdef CFG_SWITCH_READBACK_EN
  assign cfg_dout = shadow_q[TOTAL-1];
`endif

  // Returns {enable, value}; invalid side, out-of-range index or self-selection leave the pin released.
  function automatic logic [1:0] route(
    input logic [EW-1:0] e,
    input logic [2:0]    own_side,
    input int            own_idx,
    input logic [NT-1:0] t,
    input logic [NT-1:0] b,
    input logic [NS-1:0] l,
    input logic [NS-1:0] r
  );
    logic [IDXW-1:0] idx;
    logic [PW-1:0]   tp, bp, lp, rp;
    int              lim;
    idx = e[EW-1:3];
    tp  = PW'(t);
    bp  = PW'(b);
    lp  = PW'(l);
    rp  = PW'(r);
    lim = (e[2:0] == 3'd2 || e[2:0] == 3'd4) ? NS : NT;
    route = 2'b00;
    if (int'(idx) < lim && !(e[2:0] == own_side && int'(idx) == own_idx)) begin
      case (e[2:0])
        3'd1:    route = {1'b1, tp[idx]};
        3'd2:    route = {1'b1, rp[idx]};
        3'd3:    route = {1'b1, bp[idx]};
        3'd4:    route = {1'b1, lp[idx]};
        default: route = 2'b00;
      endcase
    end
  endfunction

  for (genvar i = 0; i < NT; i++) begin : g_top
    logic [1:0] rt;
    assign rt      = route(active_q[i*EW +: EW], 3'd1, i, wtop, wbottom, wleft, wright);
    assign wtop[i] = rt[1] ? rt[0] : 1'bz;
  end

  for (genvar i = 0; i < NT; i++) begin : g_bottom
    logic [1:0] rt;
    assign rt         = route(active_q[(NT+i)*EW +: EW], 3'd3, i, wtop, wbottom, wleft, wright);
    assign wbottom[i] = rt[1] ? rt[0] : 1'bz;
  end

  for (genvar i = 0; i < NS; i++) begin : g_left
    logic [1:0] rt;
    assign rt       = route(active_q[(2*NT+i)*EW +: EW], 3'd4, i, wtop, wbottom, wleft, wright);
    assign wleft[i] = rt[1] ? rt[0] : 1'bz;
  end

  for (genvar i = 0; i < NS; i++) begin : g_right
    logic [1:0] rt;
    assign rt        = route(active_q[(2*NT+NS+i)*EW +: EW], 3'd2, i, wtop, wbottom, wleft, wright);
    assign wright[i] = rt[1] ? rt[0] : 1'bz;
  end

endmodule

// File: tb/tb_cfg_switch_matrix.sv
// Bench for cfg_switch_matrix: directed protocol steps plus randomized routing images
// checked against a per-pin reference model of the configuration rules.
module tb_cfg_switch_matrix;
  localparam int NT = 5, NS = 4, IDXW = 3, EW = 6, NE = 18, TOTAL = 108;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_start = 1'b0, cfg_valid = 1'b0, cfg_din = 1'b0, cfg_commit = 1'b0;
  logic cfg_busy, cfg_ready, cfg_done, cfg_err;
`ifdef CFG_SWITCH_READBACK_EN
  logic cfg_dout;
`endif
  wire [NT-1:0] wtop, wbottom;
  wire [NS-1:0] wleft, wright;

  // Global pin numbering: 0-4 top, 5-9 bottom, 10-13 left, 14-17 right.
  logic [NE-1:0] drv_en = '0, drv_val = '0;
  logic [NE-1:0] pz, pv;
  logic [TOTAL-1:0] m_active = '0, m_shadow = '0;
  int nchk = 0, nfail = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < NT; i++) begin : g_t
    assign wtop[i] = drv_en[i] ? drv_val[i] : 1'bz;
    assign pz[i]   = (wtop[i] === 1'bz);
    assign pv[i]   = wtop[i];
  end
  for (genvar i = 0; i < NT; i++) begin : g_b
    assign wbottom[i] = drv_en[5+i] ? drv_val[5+i] : 1'bz;
    assign pz[5+i]    = (wbottom[i] === 1'bz);
    assign pv[5+i]    = wbottom[i];
  end
  for (genvar i = 0; i < NS; i++) begin : g_l
    assign wleft[i] = drv_en[10+i] ? drv_val[10+i] : 1'bz;
    assign pz[10+i] = (wleft[i] === 1'bz);
    assign pv[10+i] = wleft[i];
  end
  for (genvar i = 0; i < NS; i++) begin : g_r
    assign wright[i] = drv_en[14+i] ? drv_val[14+i] : 1'bz;
    assign pz[14+i]  = (wright[i] === 1'bz);
    assign pv[14+i]  = wright[i];
  end

  cfg_switch_matrix #(.NT(NT), .NS(NS), .IDXW(IDXW)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_start(cfg_start), .cfg_valid(cfg_valid),
    .cfg_din(cfg_din), .cfg_commit(cfg_commit), .cfg_busy(cfg_busy),
    .cfg_ready(cfg_ready), .cfg_done(cfg_done), .cfg_err(cfg_err),
`ifdef CFG_SWITCH_READBACK_EN
    .cfg_dout(cfg_dout),
`endif
    .wtop(wtop), .wbottom(wbottom), .wleft(wleft), .wright(wright)
  );

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic int side_of(input int k);
    if (k < 5) return 1;
    if (k < 10) return 3;
    if (k < 14) return 4;
    return 2;
  endfunction

  function automatic int base_of(input int side);
    case (side)
      1: return 0;
      3: return 5;
      4: return 10;
      default: return 14;
    endcase
  endfunction

  // Expected pin: 2'b10 = released, else {0, value}. Routed sources are always bench-driven here.
  function automatic logic [1:0] exp_pin(input int k);
    logic [5:0] e;
    int own_side, own_idx, side, idx, size;
    if (drv_en[k]) return {1'b0, drv_val[k]};
    own_side = side_of(k);
    own_idx  = k - base_of(own_side);
    e    = m_active[k*EW +: EW];
    side = int'(e[2:0]);
    idx  = int'(e[5:3]);
    if (side < 1 || side > 4) return 2'b10;
    size = (side == 1 || side == 3) ? NT : NS;
    if (idx >= size) return 2'b10;
    if (side == own_side && idx == own_idx) return 2'b10;
    return {1'b0, drv_val[base_of(side) + idx]};
  endfunction

  function automatic logic [TOTAL-1:0] make_img(input int ds);
    logic [TOTAL-1:0] img;
    int c;
    img = '0;
    for (int k = 0; k < NE; k++) begin
      if (side_of(k) != ds) begin
        if ($urandom_range(0, 9) < 7) begin
          img[k*EW +: EW] = {3'($urandom_range(0, 7)), 3'(ds)};
        end else begin
          c = $urandom_range(0, 3);
          img[k*EW +: EW] = {3'($urandom_range(0, 7)), (c == 0) ? 3'd0 : 3'(4 + c)};
        end
      end
    end
    return img;
  endfunction

  function automatic logic [NE-1:0] bank_mask(input int ds);
    logic [NE-1:0] m;
    m = '0;
    for (int k = 0; k < NE; k++) if (side_of(k) == ds) m[k] = 1'b1;
    return m;
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected is {busy, ready, done, err}.
  task automatic chk_status(input string tag, input logic [3:0] e);
    #1;
    chk(tag, {4'd0, cfg_busy, cfg_ready, cfg_done, cfg_err}, {4'd0, e});
  endtask

  task automatic check_pins(input string tag);
    logic [1:0] o;
    #1;
    for (int k = 0; k < NE; k++) begin
      o = pz[k] ? 2'b10 : {1'b0, pv[k]};
      chk($sformatf("%s_pin%0d", tag, k), {6'd0, o}, {6'd0, exp_pin(k)});
    end
  endtask

  task automatic shift_range(input logic [TOTAL-1:0] img, input int hi, input int lo);
    for (int b = hi; b >= lo; b--) begin
      cfg_valid = 1'b1;
      cfg_din   = img[b];
      tick();
      m_shadow = {m_shadow[TOTAL-2:0], img[b]};
    end
    cfg_valid = 1'b0;
  endtask

  task automatic load(input logic [TOTAL-1:0] img);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    shift_range(img, TOTAL - 1, 0);
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  logic [TOTAL-1:0] img, img_b;
  logic [TOTAL-1:0] rb;
  int ds;

  initial begin
    // Reset release with no load
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk_status("reset", 4'b0000);
    check_pins("reset");

    // Commit in IDLE is a protocol error
    commit();
    chk_status("idle_commit", 4'b0001);

    // wtop[0] <- wleft[2]; start and valid together drop the bit
    img = '0;
    img[0 +: EW] = {3'd2, 3'd4};
    drv_en[12] = 1'b1;
    drv_val[12] = 1'b1;
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_din = 1'b1;
    tick();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    chk_status("start_valid", 4'b1000);
    shift_range(img, TOTAL - 1, 1);
    chk_status("bit107", 4'b1000);
    shift_range(img, 0, 0);
    chk_status("bit108", 4'b0100);
    check_pins("pre_commit");
    cfg_valid = 1'b1; cfg_din = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk_status("full_valid", 4'b0101);
    commit();
    m_active = m_shadow;
    chk_status("done", 4'b0011);
    check_pins("routed");
    tick();
    chk_status("done_clear", 4'b0001);
    drv_val[12] = 1'b0;
    check_pins("follow");

    // Commit while shifting is rejected; restart and reload
    img = '0;
    img[0*EW +: EW]  = {3'd1, 3'd4};
    img[9*EW +: EW]  = {3'd3, 3'd4};
    img[17*EW +: EW] = {3'd0, 3'd4};
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    chk_status("restart", 4'b1000);
    shift_range(img, TOTAL - 1, 58);
    commit();
    chk_status("shift_commit", 4'b1001);
    check_pins("shift_commit");
    shift_range(img, 57, 0);
    chk_status("late_full", 4'b0101);
    drv_en[13:10] = 4'hf;
    drv_val[13:10] = 4'($urandom);
    load(img);
    chk_status("reload", 4'b0100);
    commit();
    m_active = m_shadow;
    chk_status("reload_done", 4'b0010);
    check_pins("reload");

    // Out-of-range index, self-selection and invalid side codes
    img = '0;
    img[5*EW +: EW]  = {3'd7, 3'd1};
    img[15*EW +: EW] = {3'd1, 3'd2};
    img[1*EW +: EW]  = {3'd3, 3'd4};
    img[14*EW +: EW] = {3'd0, 3'd4};
    img[16*EW +: EW] = {3'd2, 3'd4};
    img[6*EW +: EW]  = {3'd2, 3'd6};
    load(img);
    commit();
    m_active = m_shadow;
    check_pins("edge");
    drv_val[13:10] = ~drv_val[13:10];
    check_pins("edge_flip");

    // Random images routed from one bench-driven bank per round
    for (int r = 0; r < 8; r++) begin
      ds  = (r % 4) + 1;
      img = make_img(ds);
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
      shift_range(img, TOTAL - 1, 54);
      check_pins($sformatf("mid%0d", r));
      shift_range(img, 53, 0);
      drv_en = '0;
      commit();
      m_active = m_shadow;
      drv_en  = bank_mask(ds);
      drv_val = NE'($urandom);
      chk_status($sformatf("rnd_done%0d", r), 4'b0010);
      check_pins($sformatf("rnd%0d", r));
      drv_val = NE'($urandom);
      check_pins($sformatf("rnd_b%0d", r));
    end

    // Asynchronous reset 60 bits into a load
    img = make_img(ds);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    shift_range(img, TOTAL - 1, TOTAL - 60);
    #2;
    rst_n = 1'b0;
    m_active = '0;
    m_shadow = '0;
    check_pins("rst_mid");
    chk_status("rst_mid", 4'b0000);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    check_pins("rst_rel");
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    chk_status("idle_valid", 4'b0001);

`ifdef CFG_SWITCH_READBACK_EN
    #1;
    chk("dout_reset", {7'd0, cfg_dout}, 8'd0);
    img   = make_img(2);
    img_b = make_img(3);
    load(img);
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
    for (int b = TOTAL - 1; b >= 0; b--) begin
      rb[b]     = cfg_dout;
      cfg_valid = 1'b1;
      cfg_din   = img_b[b];
      tick();
    end
    cfg_valid = 1'b0;
    nchk++;
    assert (rb === img) else begin
      nfail++;
      $error("FAIL readback: observed %h expected %h", rb, img);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/cfg_switch_matrix.md
Name: cfg_switch_matrix

Overview:
- Parametrised FPGA routing switch box that connects four inout pin banks: top, bottom, left and right.
- The routing configuration loads at run time over a serial configuration chain into a shadow image. An explicit commit handshake then moves it to the active image.
- Each pin is driven from one selected pin on any side, or left undriven (high-Z).
- Instanced per routing tile. Tiles are chained by cfg_din/cfg_dout when the readback feature is enabled.

Parameters:
- NT, 5: pins per top bank and per bottom bank.
- NS, 4: pins per left bank and per right bank.
- IDXW, 3: pin-index field width in each entry; 2^IDXW must be at least max(NT,NS).
- Derived, not overridable:
  - EW = 3+IDXW, the entry width.
  - NE = 2*NT+2*NS, the entry count.
  - TOTAL = NE*EW, the configuration bit count.

Ports:
- clk  in  1  configuration clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_start  in  1  one-cycle pulse; begins a new configuration load.
- cfg_valid  in  1  qualifies cfg_din for one shift.
- cfg_din  in  1  serial configuration bit.
- cfg_commit  in  1  one-cycle pulse; copies the shadow image to the active image.
- cfg_busy  out  1  high in SHIFT state.
- cfg_ready  out  1  high in FULL state (all TOTAL bits received).
- cfg_done  out  1  one-cycle pulse when a commit completes.
- cfg_err  out  1  sticky protocol-error flag.
- wtop  inout  NT  top pin bank.
- wbottom  inout  NT  bottom pin bank.
- wleft  inout  NS  left pin bank.
- wright  inout  NS  right pin bank.

Behaviour:
- Entry format, EW bits: [EW-1:3] = source index, [2:0] = source side.
  - Side codes: 1 top, 2 right, 3 bottom, 4 left.
  - Codes 0, 5, 6, 7 leave the pin undriven.
- Image layout: entry k sits at bits [k*EW +: EW].
  - k = 0..NT-1: wtop.
  - Then NT entries for wbottom, NS for wleft, NS for wright.
- Shifting: shadow <= {shadow[TOTAL-2:0], cfg_din} on each accepted bit. The first bit shifted in ends up at shadow[TOTAL-1].
- Pin drive: pin = selected source pin when the active entry is valid, else 1'bz.
  - Out-of-range index (>= NT for top/bottom, >= NS for left/right) gives z.
  - An entry that selects its own pin gives z.
  - Loops through two or more pins are the loader's responsibility; they are not checked.
- State machine: IDLE, SHIFT, FULL.
  - IDLE: cfg_start -> SHIFT, with bit counter = 0 and cfg_err cleared. cfg_valid or cfg_commit in IDLE -> cfg_err=1, state unchanged.
  - SHIFT: each cfg_valid shifts one bit and increments the counter. The cycle that accepts bit TOTAL moves to FULL. cfg_commit in SHIFT -> cfg_err=1, no commit, stay in SHIFT.
  - FULL: cfg_commit -> active <= shadow on that edge; cfg_done pulses the following cycle; state -> IDLE. cfg_valid in FULL -> bit dropped, cfg_err=1.
  - cfg_start in any state restarts the load: SHIFT, counter = 0, cfg_err cleared. The shadow image is not cleared; it is fully overwritten by TOTAL shifts.
  - cfg_start and cfg_valid in the same cycle: the restart wins and the bit is dropped.
  - cfg_commit and cfg_start in the same cycle: the restart wins and no commit happens.
- The active image changes only on a commit. Pin routing is glitch-free across shifting.
- Counter width is clog2(TOTAL+1). With defaults, TOTAL = 18*6 = 108.
- Reset values:
  - state IDLE, counter 0.
  - shadow and active all 0, so every pin is z.
  - cfg_busy=0, cfg_ready=0, cfg_done=0, cfg_err=0.
- Reset asserted mid-shift or mid-commit: everything returns to the reset values immediately, and all pins release to z.

Optional Feature:
- Macro: CFG_SWITCH_READBACK_EN.
- With the macro defined:
  - Adds output cfg_dout, width 1, equal to shadow[TOTAL-1] (registered chain tail).
  - Tiles daisy-chain through it, and the image can be read back by shifting TOTAL further bits after a load. Only bits shifted while in SHIFT count.
  - cfg_dout resets to 0.
- Without the macro: the cfg_dout port does not exist, and the shadow MSB is not observable.

Test Plan:
- Reset release with no load -> all 18 pins read z. cfg_busy, cfg_ready, cfg_done and cfg_err are all 0.
- Load an image with wtop[0] entry = {index 2, side 4}, all other entries 0; drive wleft[2]=1 from the bench.
  - Before commit: wtop[0] reads z.
  - cfg_ready goes 1 after bit 108.
  - After cfg_commit: cfg_done pulses 1 cycle later, and wtop[0]=1. Then drive wleft[2]=0 -> wtop[0]=0.
- cfg_commit after 50 bits -> cfg_err=1, state stays SHIFT, active unchanged. Finish the remaining 58 bits, cfg_start, reload 108 bits and commit -> cfg_err cleared and the new routing active.
- Entries with index 7 on side 1 for wbottom[0], and wright[1] selecting itself ({1,2}) -> after commit both read z. Other routed pins unaffected.
- Assert rst_n low while 60 bits into a load that follows a committed image -> all pins immediately z and state IDLE. After release, cfg_valid alone -> cfg_err=1.
- With CFG_SWITCH_READBACK_EN: load image A, cfg_start, shift image B -> cfg_dout emits A MSB-first bit-exact over 108 cycles.
